id_ex_stage: RTL and testbench

ID/EX pipeline register with integrated load-use hazard detection for the 16-bit, 8-GPR pipelined CPU. Captures decoded operands and control from ID each cycle and presents the `*_IDEX` fields that the forwarding unit and the EX stage consume. Inserts a one-cycle bubble on a load-use dependency, freezes on an external EX hold, and squashes on a flush. Keeps a saturating count of load-use bubbles for debug.

---
 rtl/id_ex_stage_if.sv | 41 ++++
 rtl/id_ex_stage.sv | 64 ++++++
 tb/tb_id_ex_stage.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decoded ID fields in, registered IDEX fields and hazard status out
interface id_ex_stage_if #(
   parameter int DATA_WIDTH  = 16,
   parameter int ALUOP_WIDTH = 4,
   parameter int CNT_WIDTH   = 16
);
   logic [2:0]             Rx_a_ID, Ry_a_ID, Rz_a_ID, registerToWriteId_a_ID;
   logic                   usesRx_ID, usesRy_ID;
   logic [1:0]             readSpecReg_a_ID, writeSpecReg_a_ID;
   logic                   regWrite_a_ID, memRead_a_ID, memWrite_a_ID, aluSrc_a_ID;
   logic [ALUOP_WIDTH-1:0] aluOp_a_ID;
   logic [DATA_WIDTH-1:0]  readData1_ID, readData2_ID, immediate_ID, pc_ID;
   logic                   hold_EX, flush_ID;
   logic [2:0]             Rx_a_IDEX, Ry_a_IDEX, Rz_a_IDEX, registerToWriteId_a_IDEX;
   logic [1:0]             readSpecReg_a_IDEX, writeSpecReg_a_IDEX;
   logic                   regWrite_a_IDEX, memRead_a_IDEX, memWrite_a_IDEX, aluSrc_a_IDEX;
   logic [ALUOP_WIDTH-1:0] aluOp_a_IDEX;
   logic [DATA_WIDTH-1:0]  readData1_IDEX, readData2_IDEX, immediate_IDEX, pc_IDEX;
   logic                   valid_IDEX, stall_IFID;
   logic [CNT_WIDTH-1:0]   bubbleCount;
   modport master (
      output Rx_a_ID, Ry_a_ID, Rz_a_ID, registerToWriteId_a_ID, usesRx_ID, usesRy_ID,
             readSpecReg_a_ID, writeSpecReg_a_ID, regWrite_a_ID, memRead_a_ID, memWrite_a_ID,
             aluSrc_a_ID, aluOp_a_ID, readData1_ID, readData2_ID, immediate_ID, pc_ID,
             hold_EX, flush_ID,
      input  Rx_a_IDEX, Ry_a_IDEX, Rz_a_IDEX, registerToWriteId_a_IDEX, readSpecReg_a_IDEX,
             writeSpecReg_a_IDEX, regWrite_a_IDEX, memRead_a_IDEX, memWrite_a_IDEX, aluSrc_a_IDEX,
             aluOp_a_IDEX, readData1_IDEX, readData2_IDEX, immediate_IDEX, pc_IDEX,
             valid_IDEX, stall_IFID, bubbleCount
   );
   modport slave (
      input  Rx_a_ID, Ry_a_ID, Rz_a_ID, registerToWriteId_a_ID, usesRx_ID, usesRy_ID,
             readSpecReg_a_ID, writeSpecReg_a_ID, regWrite_a_ID, memRead_a_ID, memWrite_a_ID,
             aluSrc_a_ID, aluOp_a_ID, readData1_ID, readData2_ID, immediate_ID, pc_ID,
             hold_EX, flush_ID,
      output Rx_a_IDEX, Ry_a_IDEX, Rz_a_IDEX, registerToWriteId_a_IDEX, readSpecReg_a_IDEX,
             writeSpecReg_a_IDEX, regWrite_a_IDEX, memRead_a_IDEX, memWrite_a_IDEX, aluSrc_a_IDEX,
             aluOp_a_IDEX, readData1_IDEX, readData2_IDEX, immediate_IDEX, pc_IDEX,
             valid_IDEX, stall_IFID, bubbleCount
   );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion, hold and flush
module id_ex_stage (
   input logic          clk,
   input logic          rst,
   id_ex_stage_if.slave b
);
   logic load_use, gpr_hit, spec_hit;
   // a load in EX whose destination (GPR or special register) is read by the instruction in ID
   always_comb begin
      gpr_hit  = b.regWrite_a_IDEX & ((b.usesRx_ID & (b.registerToWriteId_a_IDEX == b.Rx_a_ID)) |
                                      (b.usesRy_ID & (b.registerToWriteId_a_IDEX == b.Ry_a_ID)));
      spec_hit = (b.writeSpecReg_a_IDEX != 2'b00) & (b.writeSpecReg_a_IDEX == b.readSpecReg_a_ID);
      load_use = b.valid_IDEX & b.memRead_a_IDEX & (gpr_hit | spec_hit);
      b.stall_IFID = b.hold_EX | (load_use & ~b.flush_ID);
   end
   // hold freezes everything; flush or load-use inserts a bubble keeping the data fields; else capture ID
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         b.Rx_a_IDEX <= '0;
         b.Ry_a_IDEX <= '0;
         b.Rz_a_IDEX <= '0;
         b.registerToWriteId_a_IDEX <= '0;
         b.readSpecReg_a_IDEX <= '0;
         b.writeSpecReg_a_IDEX <= '0;
         b.regWrite_a_IDEX <= 1'b0;
         b.memRead_a_IDEX <= 1'b0;
         b.memWrite_a_IDEX <= 1'b0;
         b.aluSrc_a_IDEX <= 1'b0;
         b.aluOp_a_IDEX <= '0;
         b.readData1_IDEX <= '0;
         b.readData2_IDEX <= '0;
         b.immediate_IDEX <= '0;
         b.pc_IDEX <= '0;
         b.valid_IDEX <= 1'b0;
         b.bubbleCount <= '0;
      end else if (!b.hold_EX) begin
         if (b.flush_ID | load_use) begin
            b.regWrite_a_IDEX <= 1'b0;
            b.memRead_a_IDEX <= 1'b0;
            b.memWrite_a_IDEX <= 1'b0;
            b.writeSpecReg_a_IDEX <= '0;
            b.valid_IDEX <= 1'b0;
         end else begin
            b.Rx_a_IDEX <= b.Rx_a_ID;
            b.Ry_a_IDEX <= b.Ry_a_ID;
            b.Rz_a_IDEX <= b.Rz_a_ID;
            b.registerToWriteId_a_IDEX <= b.registerToWriteId_a_ID;
            b.readSpecReg_a_IDEX <= b.readSpecReg_a_ID;
            b.writeSpecReg_a_IDEX <= b.writeSpecReg_a_ID;
            b.regWrite_a_IDEX <= b.regWrite_a_ID;
            b.memRead_a_IDEX <= b.memRead_a_ID;
            b.memWrite_a_IDEX <= b.memWrite_a_ID;
            b.aluSrc_a_IDEX <= b.aluSrc_a_ID;
            b.aluOp_a_IDEX <= b.aluOp_a_ID;
            b.readData1_IDEX <= b.readData1_ID;
            b.readData2_IDEX <= b.readData2_ID;
            b.immediate_IDEX <= b.immediate_ID;
            b.pc_IDEX <= b.pc_ID;
            b.valid_IDEX <= 1'b1;
         end
         if (load_use & ~b.flush_ID & ~&b.bubbleCount) b.bubbleCount <= b.bubbleCount + 1'b1;
      end
   end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scoreboard bench for the ID/EX register and load-use detection
module tb_id_ex_stage;
   typedef struct packed {
      logic [2:0] rx, ry, rz, rw;
      logic ux, uy;
      logic [1:0] rs, ws;
      logic we, mr, mw, as;
      logic [3:0] op;
      logic [15:0] d1, d2, imm, pc;
   } id_t;
   typedef struct packed {
      id_t f;
      logic valid;
      logic [15:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int errors = 0;
   int checks = 0;
   exp_t m, e;
   exp_t q[$];
   id_t w, c;

   always #5 clk = ~clk;

   id_ex_stage_if #(.CNT_WIDTH(16)) b();
   id_ex_stage_if #(.CNT_WIDTH(4)) s();
   id_ex_stage dut (.clk(clk), .rst(rst), .b(b));
   id_ex_stage sat (.clk(clk), .rst(rst), .b(s));

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic id_t mk(input logic [2:0] rx, input logic [2:0] ry, input logic [2:0] rw,
                              input logic ux, input logic uy, input logic we, input logic mr,
                              input logic [1:0] rs, input logic [1:0] ws);
      id_t x;
      x.rx = rx; x.ry = ry; x.rw = rw; x.ux = ux; x.uy = uy; x.we = we; x.mr = mr;
      x.rs = rs; x.ws = ws; x.mw = 1'($urandom); x.as = 1'($urandom); x.rz = 3'($urandom);
      x.op = 4'($urandom); x.d1 = 16'($urandom); x.d2 = 16'($urandom);
      x.imm = 16'($urandom); x.pc = 16'($urandom);
      return x;
   endfunction

   function automatic id_t rnd();
      return mk(3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                2'($urandom), 2'($urandom));
   endfunction

   task automatic drive(input id_t x, input logic h, input logic f);
      b.Rx_a_ID = x.rx; b.Ry_a_ID = x.ry; b.Rz_a_ID = x.rz; b.registerToWriteId_a_ID = x.rw;
      b.usesRx_ID = x.ux; b.usesRy_ID = x.uy; b.readSpecReg_a_ID = x.rs; b.writeSpecReg_a_ID = x.ws;
      b.regWrite_a_ID = x.we; b.memRead_a_ID = x.mr; b.memWrite_a_ID = x.mw; b.aluSrc_a_ID = x.as;
      b.aluOp_a_ID = x.op; b.readData1_ID = x.d1; b.readData2_ID = x.d2;
      b.immediate_ID = x.imm; b.pc_ID = x.pc; b.hold_EX = h; b.flush_ID = f;
   endtask

   task automatic compare(input string tag, input exp_t x);
      chk({tag, ".valid"}, 16'(b.valid_IDEX), 16'(x.valid));
      chk({tag, ".regWrite"}, 16'(b.regWrite_a_IDEX), 16'(x.f.we));
      chk({tag, ".memRead"}, 16'(b.memRead_a_IDEX), 16'(x.f.mr));
      chk({tag, ".memWrite"}, 16'(b.memWrite_a_IDEX), 16'(x.f.mw));
      chk({tag, ".writeSpec"}, 16'(b.writeSpecReg_a_IDEX), 16'(x.f.ws));
      chk({tag, ".bubbleCount"}, b.bubbleCount, x.cnt);
      if (x.valid) begin
         chk({tag, ".Rx"}, 16'(b.Rx_a_IDEX), 16'(x.f.rx));
         chk({tag, ".Ry"}, 16'(b.Ry_a_IDEX), 16'(x.f.ry));
         chk({tag, ".Rz"}, 16'(b.Rz_a_IDEX), 16'(x.f.rz));
         chk({tag, ".rwId"}, 16'(b.registerToWriteId_a_IDEX), 16'(x.f.rw));
         chk({tag, ".readSpec"}, 16'(b.readSpecReg_a_IDEX), 16'(x.f.rs));
         chk({tag, ".aluSrc"}, 16'(b.aluSrc_a_IDEX), 16'(x.f.as));
         chk({tag, ".aluOp"}, 16'(b.aluOp_a_IDEX), 16'(x.f.op));
         chk({tag, ".rd1"}, b.readData1_IDEX, x.f.d1);
         chk({tag, ".rd2"}, b.readData2_IDEX, x.f.d2);
         chk({tag, ".imm"}, b.immediate_IDEX, x.f.imm);
         chk({tag, ".pc"}, b.pc_IDEX, x.f.pc);
      end
   endtask

   // drive one cycle of ID input, check the same-cycle stall, push the expected register state,
   // then pop and compare it after the edge
   task automatic step(input string tag, input id_t x, input logic h, input logic f);
      logic lu, st;
      exp_t n;
      drive(x, h, f);
      #1;
      lu = m.valid && m.f.mr &&
           ((m.f.we && ((x.ux && m.f.rw == x.rx) || (x.uy && m.f.rw == x.ry))) ||
            (m.f.ws != 2'b00 && m.f.ws == x.rs));
      st = h || (lu && !f);
      chk({tag, ".stall"}, 16'(b.stall_IFID), 16'(st));
      n = m;
      if (!h) begin
         if (f || lu) begin
            n.f.we = 1'b0; n.f.mr = 1'b0; n.f.mw = 1'b0; n.f.ws = 2'b00; n.valid = 1'b0;
            if (!f && n.cnt != 16'hFFFF) n.cnt = n.cnt + 16'd1;
         end else begin
            n.f = x; n.valid = 1'b1;
         end
      end
      m = n;
      q.push_back(n);
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
         errors++;
         $error("FAIL %s.queue: observed=empty expected=entry", tag);
      end else begin
         e = q.pop_front();
         compare(tag, e);
      end
   endtask

   initial begin
      m = '0;
      s.Rx_a_ID = 3'd3; s.Ry_a_ID = 3'd0; s.Rz_a_ID = 3'd0; s.registerToWriteId_a_ID = 3'd3;
      s.usesRx_ID = 1'b1; s.usesRy_ID = 1'b0; s.readSpecReg_a_ID = 2'd0; s.writeSpecReg_a_ID = 2'd0;
      s.regWrite_a_ID = 1'b1; s.memRead_a_ID = 1'b1; s.memWrite_a_ID = 1'b0; s.aluSrc_a_ID = 1'b1;
      s.aluOp_a_ID = 4'd0; s.readData1_ID = 16'd0; s.readData2_ID = 16'd0; s.immediate_ID = 16'd4;
      s.pc_ID = 16'd1; s.hold_EX = 1'b0; s.flush_ID = 1'b0;
      drive(rnd(), 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      compare("reset", m);
      chk("reset.Rx", 16'(b.Rx_a_IDEX), 16'd0);
      chk("reset.rd1", b.readData1_IDEX, 16'd0);
      chk("reset.pc", b.pc_IDEX, 16'd0);
      chk("reset.stall", 16'(b.stall_IFID), 16'd0);
      rst = 1'b1;
      w = mk(3'd2, 3'd3, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0);
      step("addu", w, 1'b0, 1'b0);
      chk("addu.Rx_is_2", 16'(b.Rx_a_IDEX), 16'd2);
      w = mk(3'd2, 3'd0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0);
      step("lw_r3", w, 1'b0, 1'b0);
      c = mk(3'd3, 3'd4, 3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0);
      step("lu_bubble", c, 1'b0, 1'b0);
      chk("lu_bubble.count1", b.bubbleCount, 16'd1);
      step("lu_release", c, 1'b0, 1'b0);
      step("lw_r3b", w, 1'b0, 1'b0);
      step("no_false", mk(3'd3, 3'd1, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0), 1'b0, 1'b0);
      step("lw_r5", mk(3'd1, 3'd0, 3'd5, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0), 1'b0, 1'b0);
      c = mk(3'd1, 3'd5, 3'd6, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0);
      step("ry_bubble", c, 1'b0, 1'b0);
      step("ry_release", c, 1'b0, 1'b0);
      w = mk(3'd1, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1);
      step("lw_spec", w, 1'b0, 1'b0);
      c = mk(3'd1, 3'd2, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0);
      step("spec_bubble", c, 1'b0, 1'b0);
      step("spec_release", c, 1'b0, 1'b0);
      step("lw_spec2", w, 1'b0, 1'b0);
      step("spec_other", mk(3'd1, 3'd2, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 2'd0), 1'b0, 1'b0);
      step("pre_hold", mk(3'd6, 3'd7, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step("hold_flush", rnd(), 1'b1, 1'b1);
      step("flush_after_hold", rnd(), 1'b0, 1'b1);
      w = mk(3'd2, 3'd0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0);
      c = mk(3'd3, 3'd4, 3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0);
      step("lw_hold", w, 1'b0, 1'b0);
      step("hold_lu", c, 1'b1, 1'b0);
      step("hold_lu2", c, 1'b1, 1'b0);
      step("lu_after_hold", c, 1'b0, 1'b0);
      step("lw_flush", w, 1'b0, 1'b0);
      step("flush_lu", c, 1'b0, 1'b1);
      for (int i = 0; i < 60; i++)
         step("random", rnd(), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
      step("lw_rst", w, 1'b0, 1'b0);
      drive(c, 1'b0, 1'b0);
      #1;
      chk("rst_mid.stall_before", 16'(b.stall_IFID), 16'd1);
      rst = 1'b0;
      #1;
      m = '0;
      compare("rst_mid", m);
      chk("rst_mid.stall", 16'(b.stall_IFID), 16'd0);
      rst = 1'b1;
      #1;
      step("after_rst", c, 1'b0, 1'b0);
      rst = 1'b0;
      #2;
      rst = 1'b1;
      repeat (29) @(posedge clk);
      #1;
      chk("sat.count14", 16'(s.bubbleCount), 16'd14);
      repeat (2) @(posedge clk);
      #1;
      chk("sat.count15", 16'(s.bubbleCount), 16'd15);
      repeat (10) @(posedge clk);
      #1;
      chk("sat.hold_max", 16'(s.bubbleCount), 16'd15);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
